// File: rtl/bcd_to_84n2n1_serializer.sv
// bcd_to_84n2n1_serializer: serializes a packed BCD word into 8,4,-2,-1 digits, MSD first.
// Optional CODE_PARITY_EN adds out_par, the odd parity of out_code.
module bcd_to_84n2n1_serializer #(
  parameter int DIGITS = 4,
  parameter int IDXW   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_code,
  output logic [IDXW-1:0]       out_idx,
  output logic                  out_last,
  output logic                  out_err,
  output logic                  word_err
`ifdef CODE_PARITY_EN
  ,
  output logic                  out_par
`endif
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [4*DIGITS-1:0] sr;
  logic [3:0] dig, code;
  logic bad;
  function automatic logic [3:0] enc(input logic [3:0] d);
    case (d)
      4'd1: enc = 4'b0111;
      4'd2: enc = 4'b0110;
      4'd3: enc = 4'b0101;
      4'd4: enc = 4'b0100;
      4'd5: enc = 4'b1011;
      4'd6: enc = 4'b1010;
      4'd7: enc = 4'b1001;
      4'd8: enc = 4'b1000;
      4'd9: enc = 4'b1111;
      default: enc = 4'b0000;
    endcase
  endfunction
  // sr keeps the not-yet-presented digits left-aligned, so the next one is always on top
  assign dig = state == IDLE ? in_bcd[4*DIGITS-1 -: 4] : sr[4*DIGITS-1 -: 4];
  assign code = enc(dig);
  assign in_ready = state == IDLE && rst_n;
  assign out_valid = state == SEND;
  always_comb begin
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) bad = bad | (in_bcd[4*k +: 4] > 4'd9);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      out_code <= 4'b0000;
      out_idx  <= '0;
      out_last <= 1'b0;
      out_err  <= 1'b0;
      word_err <= 1'b0;
`ifdef CODE_PARITY_EN
      out_par  <= 1'b1;
`endif
    end else if (state == IDLE) begin
      if (in_valid) begin
        state    <= SEND;
        sr       <= in_bcd << 4;
        out_code <= code;
        out_idx  <= IDXW'(DIGITS - 1);
        out_last <= DIGITS == 1;
        out_err  <= dig > 4'd9;
        word_err <= bad;
`ifdef CODE_PARITY_EN
        out_par  <= ~^code;
`endif
      end
    end else if (out_ready) begin
      if (out_last) state <= IDLE;
      else begin
        sr       <= sr << 4;
        out_code <= code;
        out_idx  <= out_idx - IDXW'(1);
        out_last <= out_idx == IDXW'(1);
        out_err  <= dig > 4'd9;
`ifdef CODE_PARITY_EN
        out_par  <= ~^code;
`endif
      end
    end
  end
endmodule
